// File: rtl/alu_exec_sequencer.sv
// Execute-stage controller for the Y86-64 ALU.
// Accepts one operation per request and holds its operands on the ALU for
// EXEC_CYCLES cycles. It then captures the result, optionally updates
// ZF/SF/OF, and evaluates the jXX/cmovXX condition.
module alu_exec_sequencer #(
  parameter int         WIDTH       = 64,
  parameter int         EXEC_CYCLES = 1,
  parameter logic [2:0] CC_RESET    = 3'b100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_fn,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_setcc,
  input  logic [2:0]       req_cond,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic                    rsp_valid_q;
  logic [WIDTH-1:0]        rsp_result_q;
  logic                    rsp_cnd_q;
  logic [2:0]              cc_q;
  logic [1:0]              fn_q;
  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic                    setcc_q;
  logic [2:0]              cond_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [WIDTH:0]          alu_d;
  logic [WIDTH-1:0]        alu_res_d;
  logic [2:0]              cc_d;
  logic                    cnd_d;

  // ALU: {overflow, result}; overflow only meaningful for add/sub.
  function automatic logic [WIDTH:0] alu_calc(input logic [1:0] fn,
                                                input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] r;
    logic                    of;
    r  = '0;
    of = 1'b0;
    case (fn)
      2'b00: begin
        r  = a + b;
        of = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        r  = a - b;
        of = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
    return {of, r};
  endfunction

  // Condition evaluation on a {ZF,SF,OF} triple.
  function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] cc);
    logic zf, sf, of;
    logic res;
    {zf, sf, of} = cc;
    case (cond)
      3'd0:    res = 1'b1;
      3'd1:    res = (sf ^ of) | zf;
      3'd2:    res = sf ^ of;
      3'd3:    res = zf;
      3'd4:    res = ~zf;
      3'd5:    res = ~(sf ^ of);
      3'd6:    res = ~(sf ^ of) & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // ALU driven from latched operands only; condition sees post-update CC.
  always_comb begin
    alu_d     = alu_calc(fn_q, a_q, b_q);
    alu_res_d = alu_d[WIDTH-1:0];
    cc_d      = cc_q;
    if (setcc_q) begin
      cc_d = {(alu_res_d == '0), alu_res_d[WIDTH-1], alu_d[WIDTH]};
    end
    cnd_d     = cond_eval(cond_q, cc_d);
  end

  // Sequencer FSM with registered outputs; flush aborts without touching CC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cnd_q    <= 1'b0;
      cc_q         <= CC_RESET;
      fn_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      setcc_q      <= 1'b0;
      cond_q       <= 3'd0;
      cnt_q        <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            fn_q    <= req_fn;
            a_q     <= req_a;
            b_q     <= req_b;
            setcc_q <= req_setcc;
            cond_q  <= req_cond;
            cnt_q   <= CNT_W'(EXEC_CYCLES - 1);
            ready_q <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_result_q <= alu_res_d;
            cc_q         <= cc_d;
            rsp_cnd_q    <= cnd_d;
            rsp_valid_q  <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = ready_q & ~flush;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cnd    = rsp_cnd_q;
  assign cc_zf      = cc_q[2];
  assign cc_sf      = cc_q[1];
  assign cc_of      = cc_q[0];

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Bench for alu_exec_sequencer: directed and random operations checked
// against an arithmetic reference model of the ALU and condition codes.
module tb_alu_exec_sequencer;

  localparam int W     = 64;
  localparam int EXEC1 = 1;
  localparam int EXEC4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         flush, req_valid, req_ready, req_setcc, rsp_valid, rsp_ready, rsp_cnd;
  logic [1:0]   req_fn;
  logic [W-1:0] req_a, req_b, rsp_result;
  logic [2:0]   req_cond;
  logic         cc_zf, cc_sf, cc_of;

  logic         flush4, req_valid4, req_ready4, req_setcc4, rsp_valid4, rsp_ready4, rsp_cnd4;
  logic [1:0]   req_fn4;
  logic [W-1:0] req_a4, req_b4, rsp_result4;
  logic [2:0]   req_cond4;
  logic         cc_zf4, cc_sf4, cc_of4;

  alu_exec_sequencer #(.WIDTH(W), .EXEC_CYCLES(EXEC1), .CC_RESET(3'b100)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn),
    .req_a(req_a), .req_b(req_b), .req_setcc(req_setcc), .req_cond(req_cond),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cnd(rsp_cnd), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  alu_exec_sequencer #(.WIDTH(W), .EXEC_CYCLES(EXEC4), .CC_RESET(3'b100)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush4),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_fn(req_fn4),
    .req_a(req_a4), .req_b(req_b4), .req_setcc(req_setcc4), .req_cond(req_cond4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_result(rsp_result4),
    .rsp_cnd(rsp_cnd4), .cc_zf(cc_zf4), .cc_sf(cc_sf4), .cc_of(cc_of4)
  );

  int checks = 0;
  int errors = 0;

  // Reference architectural condition codes.
  logic mzf, msf, mof;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_cnd(input logic [2:0] cond, input logic zf, input logic sf, input logic of);
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return (sf ^ of) | zf;
      3'd2:    return sf ^ of;
      3'd3:    return zf;
      3'd4:    return !zf;
      3'd5:    return !(sf ^ of);
      3'd6:    return !(sf ^ of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Issue one op, track latency, optionally stall the response for 'hold' cycles.
  task automatic run_op(input logic [1:0] fn, input logic [63:0] a, input logic [63:0] b,
                        input logic setcc, input logic [2:0] cond, input int hold);
    logic [64:0] ext;
    logic [63:0] er;
    logic        eo, ecnd;
    int          lat;
    case (fn)
      2'd0:    ext = {a[63], a} + {b[63], b};
      2'd1:    ext = {a[63], a} - {b[63], b};
      2'd2:    ext = {1'b0, a & b};
      default: ext = {1'b0, a ^ b};
    endcase
    er = ext[63:0];
    eo = (fn < 2'd2) ? (ext[64] ^ ext[63]) : 1'b0;
    if (setcc) begin
      mzf = (er == 64'd0);
      msf = er[63];
      mof = eo;
    end
    ecnd = model_cnd(cond, mzf, msf, mof);

    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'd1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_fn = fn; req_a = a; req_b = b; req_setcc = setcc; req_cond = cond;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a = ~a;
    req_b = $urandom;
    lat = 0;
    forever begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid || lat >= 20) break;
    end
    chk("latency", 64'(lat), 64'(EXEC1));
    chk("result", rsp_result, er);
    chk("cnd", 64'(rsp_cnd), 64'(ecnd));
    chk("cc", 64'({cc_zf, cc_sf, cc_of}), 64'({mzf, msf, mof}));
    for (int i = 0; i < hold; i++) begin
      req_valid = $urandom_range(0, 1);
      req_a = {$urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_result", rsp_result, er);
      chk("hold_cnd", 64'(rsp_cnd), 64'(ecnd));
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("ret_valid", 64'(rsp_valid), 64'd0);
    chk("ret_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    int lat4;
    logic [63:0] ra, rb;
    flush = 0; req_valid = 0; req_fn = 0; req_a = 0; req_b = 0;
    req_setcc = 0; req_cond = 0; rsp_ready = 1;
    flush4 = 0; req_valid4 = 0; req_fn4 = 0; req_a4 = 0; req_b4 = 0;
    req_setcc4 = 0; req_cond4 = 0; rsp_ready4 = 1;
    {mzf, msf, mof} = 3'b100;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_result", rsp_result, 64'd0);
    chk("rst_cnd", 64'(rsp_cnd), 64'd0);
    chk("rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'(3'b100));
    rst_n = 1'b1;

    // Directed cases
    run_op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'd0, 0);
    chk("t1_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t1_cc", 64'({cc_zf, cc_sf, cc_of}), 64'(3'b011));
    run_op(2'd0, 64'd0, 64'd0, 1'b0, 3'd6, 0);
    chk("t4_cc", 64'({cc_zf, cc_sf, cc_of}), 64'(3'b011));
    run_op(2'd1, 64'd5, 64'd5, 1'b1, 3'd3, 0);
    chk("t2_cnd", 64'(rsp_cnd), 64'd1);
    run_op(2'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 3'd2, 0);
    chk("t2b_cc", 64'({cc_zf, cc_sf, cc_of}), 64'(3'b001));
    run_op(2'd2, 64'h5, 64'hE, 1'b1, 3'd0, 0);
    chk("t3_and", rsp_result, 64'h4);
    run_op(2'd3, 64'h5, 64'hE, 1'b1, 3'd4, 3);
    chk("t3_xor", rsp_result, 64'hB);

    // Random operations with occasional response stalls
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = 64'h8000_0000_0000_0000; rb = {$urandom, $urandom}; end
        1: begin ra = {$urandom, $urandom}; rb = ra; end
        default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
      endcase
      run_op(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    // Make CC distinct from what the flushed op would produce
    run_op(2'd1, 64'd9, 64'd9, 1'b1, 3'd0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_fn = 2'd0; req_a = 64'd1; req_b = 64'd1;
    req_setcc = 1'b1; req_cond = 3'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 64'(rsp_valid), 64'd0);
    chk("flush_idle", 64'(req_ready), 64'd1);
    chk("flush_cc", 64'({cc_zf, cc_sf, cc_of}), 64'({mzf, msf, mof}));
    repeat (2) @(negedge clk);
    chk("flush_novalid", 64'(rsp_valid), 64'd0);

    // Flush wins over a request in IDLE
    flush = 1'b1; req_valid = 1'b1;
    #1;
    chk("flush_idle_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("flush_noaccept", 64'(rsp_valid), 64'd0);
    end

    // EXEC_CYCLES=4 instance latency
    @(negedge clk);
    req_valid4 = 1'b1; req_fn4 = 2'd0; req_a4 = 64'd3; req_b4 = 64'd4;
    req_setcc4 = 1'b1; req_cond4 = 3'd4;
    @(posedge clk);
    #1;
    req_valid4 = 1'b0;
    req_a4 = 64'd100;
    lat4 = 0;
    forever begin
      @(posedge clk);
      lat4++;
      @(negedge clk);
      if (rsp_valid4 || lat4 >= 20) break;
    end
    chk("lat4", 64'(lat4), 64'(EXEC4));
    chk("lat4_result", rsp_result4, 64'd7);
    chk("lat4_cc", 64'({cc_zf4, cc_sf4, cc_of4}), 64'(3'b000));
    chk("lat4_cnd", 64'(rsp_cnd4), 64'd1);

    // Asynchronous reset while in DONE
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_fn = 2'd1; req_a = 64'd1; req_b = 64'd2;
    req_setcc = 1'b1; req_cond = 3'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_ready", 64'(req_ready), 64'd1);
    chk("arst_result", rsp_result, 64'd0);
    chk("arst_cnd", 64'(rsp_cnd), 64'd0);
    chk("arst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'(3'b100));
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    {mzf, msf, mof} = 3'b100;
    run_op(2'd0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 3'd3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
